// File: rtl/fifo_wr_packer.sv
// Write-domain byte packer: takes 1- or 2-byte result words over valid/ready and
// feeds them one byte at a time into the async FIFO write port, retrying while full.
module fifo_wr_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                    W_CLK,
    input  logic                    W_RST,
    input  logic                    IN_VALID,
    input  logic [2*DATA_WIDTH-1:0] IN_DATA,
    input  logic                    IN_TWO_BYTES,
    output logic                    IN_READY,
    input  logic                    WR_FULL,
    output logic                    WR_INC,
    output logic [DATA_WIDTH-1:0]   WR_DATA,
    output logic                    BUSY,
    output logic [CNT_WIDTH-1:0]    BYTE_CNT
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_LO = 2'd1,
        SEND_HI = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    two_bytes;
    logic                    two_bytes_nxt;
    logic                    wr_inc_nxt;
    logic [DATA_WIDTH-1:0]   wr_data_nxt;
    logic [DATA_WIDTH-1:0]   hi_byte;
    logic                    load_word;
    logic                    accept;

    // Same acceptance rule the FIFO write-pointer stage applies
    assign accept   = WR_INC && !WR_FULL;
    assign IN_READY = (state == IDLE);
    assign BUSY     = (state != IDLE);

    always_comb begin
        state_nxt     = state;
        two_bytes_nxt = two_bytes;
        wr_inc_nxt    = WR_INC;
        wr_data_nxt   = WR_DATA;
        load_word     = 1'b0;
        case (state)
            IDLE: begin
                wr_inc_nxt = 1'b0;
                if (IN_VALID) begin
                    load_word     = 1'b1;
                    two_bytes_nxt = IN_TWO_BYTES;
                    wr_data_nxt   = IN_DATA[DATA_WIDTH-1:0];
                    wr_inc_nxt    = 1'b1;
                    state_nxt     = SEND_LO;
                end
            end
            SEND_LO: begin
                if (accept) begin
                    if (two_bytes) begin
                        // Keep the strobe high so the high byte follows with no gap
                        wr_data_nxt = hi_byte;
                        state_nxt   = SEND_HI;
                    end else begin
                        wr_inc_nxt = 1'b0;
                        state_nxt  = IDLE;
                    end
                end
            end
            SEND_HI: begin
                if (accept) begin
                    wr_inc_nxt = 1'b0;
                    state_nxt  = IDLE;
                end
            end
            default: begin
                wr_inc_nxt = 1'b0;
                state_nxt  = IDLE;
            end
        endcase
    end

    always_ff @(posedge W_CLK or negedge W_RST) begin
        if (!W_RST) begin
            state     <= IDLE;
            two_bytes <= 1'b0;
            WR_INC    <= 1'b0;
            WR_DATA   <= '0;
            BYTE_CNT  <= '0;
        end else begin
            state     <= state_nxt;
            two_bytes <= two_bytes_nxt;
            WR_INC    <= wr_inc_nxt;
            WR_DATA   <= wr_data_nxt;
            if (accept) begin
                BYTE_CNT <= BYTE_CNT + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    // High byte is pure data; it is only consumed after being loaded
    always_ff @(posedge W_CLK) begin
        if (load_word) begin
            hi_byte <= IN_DATA[2*DATA_WIDTH-1:DATA_WIDTH];
        end
    end

endmodule

// File: tb/tb_fifo_wr_packer.sv
// Self-checking bench for fifo_wr_packer: a queue-of-bytes model checked every cycle,
// plus directed scenarios with hand-computed byte sequences and counts.
module tb_fifo_wr_packer;

    logic        W_CLK = 1'b0;
    logic        W_RST = 1'b0;
    logic        IN_VALID = 1'b0;
    logic [15:0] IN_DATA = 16'h0000;
    logic        IN_TWO_BYTES = 1'b0;
    logic        IN_READY;
    logic        WR_FULL = 1'b0;
    logic        WR_INC;
    logic [7:0]  WR_DATA;
    logic        BUSY;
    logic [7:0]  BYTE_CNT;

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic [7:0] mcnt = 8'h00;
    logic [7:0] wlog[$];

    fifo_wr_packer #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
        .W_CLK(W_CLK), .W_RST(W_RST), .IN_VALID(IN_VALID), .IN_DATA(IN_DATA),
        .IN_TWO_BYTES(IN_TWO_BYTES), .IN_READY(IN_READY), .WR_FULL(WR_FULL),
        .WR_INC(WR_INC), .WR_DATA(WR_DATA), .BUSY(BUSY), .BYTE_CNT(BYTE_CNT)
    );

    always #5 W_CLK = ~W_CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: bytes still owed to the FIFO, in order. The packer is ready exactly
    // when nothing is owed; the head of the queue is what must be on WR_DATA.
    initial begin
        forever begin
            @(posedge W_CLK or negedge W_RST);
            if (!W_RST) begin
                exp_q.delete();
                mcnt = 8'h00;
            end else begin
                bit was_empty;
                if (WR_INC && !WR_FULL) wlog.push_back(WR_DATA);
                was_empty = (exp_q.size() == 0);
                if (!was_empty && !WR_FULL) begin
                    void'(exp_q.pop_front());
                    mcnt = mcnt + 8'h01;
                end
                if (was_empty && IN_VALID) begin
                    exp_q.push_back(IN_DATA[7:0]);
                    if (IN_TWO_BYTES) exp_q.push_back(IN_DATA[15:8]);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge W_CLK);
            check("model_in_ready", IN_READY, exp_q.size() == 0);
            check("model_busy", BUSY, exp_q.size() != 0);
            check("model_wr_inc", WR_INC, exp_q.size() != 0);
            check("model_byte_cnt", BYTE_CNT, mcnt);
            if (exp_q.size() != 0) check("model_wr_data", WR_DATA, exp_q[0]);
        end
    end

    task automatic step();
        @(posedge W_CLK);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input bit two);
        int n = 0;
        IN_DATA = d;
        IN_TWO_BYTES = two;
        IN_VALID = 1'b1;
        while (!IN_READY && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) begin
            failures++;
            $display("FAIL send_timeout actual=busy required=ready");
        end
        step();
        IN_VALID = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!IN_READY && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) begin
            failures++;
            $display("FAIL idle_timeout actual=busy required=idle");
        end
    endtask

    logic [7:0] stream_exp[8];
    int s;

    initial begin
        stream_exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

        // Reset state
        #2;
        check("rst_in_ready", IN_READY, 1);
        check("rst_wr_inc", WR_INC, 0);
        check("rst_wr_data", WR_DATA, 8'h00);
        check("rst_busy", BUSY, 0);
        check("rst_byte_cnt", BYTE_CNT, 8'h00);
        repeat (3) step();
        W_RST = 1'b1;
        step();

        // Two-byte word, FIFO never full
        send(16'hA55A, 1'b1);
        check("t2_n1_ready", IN_READY, 0);
        check("t2_n1_inc", WR_INC, 1);
        check("t2_n1_data", WR_DATA, 8'h5A);
        step();
        check("t2_n2_ready", IN_READY, 0);
        check("t2_n2_data", WR_DATA, 8'hA5);
        step();
        check("t2_n3_ready", IN_READY, 1);
        check("t2_n3_inc", WR_INC, 0);
        check("t2_cnt", BYTE_CNT, 8'd2);
        check("t2_nwrites", wlog.size(), 2);
        check("t2_b0", wlog[0], 8'h5A);
        check("t2_b1", wlog[1], 8'hA5);

        // One-byte word
        send(16'h1234, 1'b0);
        check("t3_data", WR_DATA, 8'h34);
        step();
        check("t3_ready", IN_READY, 1);
        check("t3_inc", WR_INC, 0);
        check("t3_cnt", BYTE_CNT, 8'd3);
        check("t3_nwrites", wlog.size(), 3);
        check("t3_b", wlog[2], 8'h34);

        // FIFO full for five cycles while the low byte is pending
        WR_FULL = 1'b1;
        send(16'hA55A, 1'b1);
        repeat (5) begin
            step();
            check("t4_hold_data", WR_DATA, 8'h5A);
            check("t4_hold_inc", WR_INC, 1);
            check("t4_hold_cnt", BYTE_CNT, 8'd3);
        end
        WR_FULL = 1'b0;
        wait_idle();
        check("t4_nwrites", wlog.size(), 5);
        check("t4_b0", wlog[3], 8'h5A);
        check("t4_b1", wlog[4], 8'hA5);
        check("t4_cnt", BYTE_CNT, 8'd5);

        // Reset asserted while the high byte is stalled
        send(16'h7788, 1'b1);
        step();
        WR_FULL = 1'b1;
        step();
        check("t1_pre_busy", BUSY, 1);
        W_RST = 1'b0;
        #1;
        check("t1_inc", WR_INC, 0);
        check("t1_cnt", BYTE_CNT, 8'd0);
        check("t1_ready", IN_READY, 1);
        s = wlog.size();
        check("t1_pre_writes", s, 6);
        WR_FULL = 1'b0;
        repeat (3) step();
        check("t1_no_write", wlog.size(), s);
        W_RST = 1'b1;
        step();
        check("t1_no_write_after", wlog.size(), s);

        // Streaming with WR_FULL toggling every cycle
        s = wlog.size();
        fork
            begin
                repeat (60) begin
                    step();
                    WR_FULL = ~WR_FULL;
                end
                WR_FULL = 1'b0;
            end
            begin
                send(16'h2211, 1'b1);
                send(16'h4433, 1'b1);
                send(16'h6655, 1'b1);
                send(16'h8877, 1'b1);
            end
        join
        wait_idle();
        check("t5_nwrites", wlog.size(), s + 8);
        for (int i = 0; i < 8; i++) check("t5_byte", wlog[s + i], stream_exp[i]);
        check("t5_cnt", BYTE_CNT, 8'd8);

        // New word offered while busy must be ignored
        WR_FULL = 1'b1;
        send(16'hBEEF, 1'b1);
        IN_DATA = 16'hDEAD;
        IN_TWO_BYTES = 1'b0;
        IN_VALID = 1'b1;
        repeat (3) begin
            step();
            check("t6_busy_ready", IN_READY, 0);
            check("t6_busy_data", WR_DATA, 8'hEF);
        end
        IN_VALID = 1'b0;
        WR_FULL = 1'b0;
        wait_idle();
        s = wlog.size();
        check("t6_b0", wlog[s - 2], 8'hEF);
        check("t6_b1", wlog[s - 1], 8'hBE);
        check("t6_cnt10", BYTE_CNT, 8'd10);

        // Wrap: 10 + 123*2 = 256 bytes
        for (int i = 0; i < 123; i++) send(16'(i * 3 + 1), 1'b1);
        wait_idle();
        check("t6_wrap_cnt", BYTE_CNT, 8'd0);
        check("t6_wrap_writes", wlog.size(), s + 246);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
